// File: rtl/mm_pkg.sv
// Shared types and default sizes for the matrix-multiply host sequencer,
// multiplier and operand/result buffers.
package mm_pkg;

    localparam int MM_N  = 2;
    localparam int MM_DW = 8;
    localparam int MM_RW = 16;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_A,
        ST_LOAD_B,
        ST_START,
        ST_COMPUTE,
        ST_READ,
        ST_SEND,
        ST_TX_WAIT
    } mm_ctrl_state_t;

    // Internal phases of the result sender; LATCH and GUARD are the
    // one-cycle sub-steps of READ and TX_WAIT.
    typedef enum logic [2:0] {
        SND_IDLE,
        SND_READ,
        SND_LATCH,
        SND_SEND,
        SND_GUARD,
        SND_WAIT
    } mm_send_state_t;

    function automatic int byte_idx_width(input int rw);
        return (rw / 8 > 1) ? $clog2(rw / 8) : 1;
    endfunction

endpackage

// File: rtl/mm_result_sender.sv
// Reads each result element and streams it to the UART transmitter MSB first;
// pulses done after the last byte of the last element has left the transmitter.
module mm_result_sender
    import mm_pkg::*;
#(
    parameter int N  = MM_N,
    parameter int RW = MM_RW,
    parameter int AW = $clog2(N * N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          done,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [RW-1:0] rd_data,
    output logic [7:0]    tx_data,
    output logic          tx_start,
    input  logic          tx_busy
);

    localparam int NB  = RW / 8;
    localparam int BIW = byte_idx_width(RW);
    localparam logic [AW:0]    LAST_IDX  = (AW + 1)'(N * N - 1);
    localparam logic [BIW-1:0] LAST_BYTE = BIW'(NB - 1);

    mm_send_state_t state, state_next;
    logic [AW:0]    cnt, cnt_next;
    logic [BIW-1:0] byte_idx, byte_next;
    logic [RW-1:0]  shreg, shreg_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= SND_IDLE;
            cnt      <= '0;
            byte_idx <= '0;
            shreg    <= '0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            byte_idx <= byte_next;
            shreg    <= shreg_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        byte_next  = byte_idx;
        shreg_next = shreg;
        done       = 1'b0;
        rd_en      = 1'b0;
        rd_addr    = '0;
        tx_data    = 8'h00;
        tx_start   = 1'b0;
        case (state)
            SND_IDLE: begin
                if (start) begin
                    cnt_next   = '0;
                    state_next = SND_READ;
                end
            end
            SND_READ: begin
                rd_en      = 1'b1;
                rd_addr    = cnt[AW-1:0];
                state_next = SND_LATCH;
            end
            // The result buffer answers exactly one cycle after rd_en.
            SND_LATCH: begin
                shreg_next = rd_data;
                byte_next  = LAST_BYTE;
                state_next = SND_SEND;
            end
            SND_SEND: begin
                if (!tx_busy) begin
                    tx_start   = 1'b1;
                    tx_data    = shreg[RW-1 -: 8];
                    state_next = SND_GUARD;
                end
            end
            // The transmitter may not raise tx_busy until a cycle after tx_start.
            SND_GUARD: begin
                state_next = SND_WAIT;
            end
            SND_WAIT: begin
                if (!tx_busy) begin
                    if (byte_idx != '0) begin
                        byte_next  = byte_idx - BIW'(1);
                        shreg_next = shreg << 8;
                        state_next = SND_SEND;
                    end else if (cnt < LAST_IDX) begin
                        cnt_next   = cnt + (AW + 1)'(1);
                        state_next = SND_READ;
                    end else begin
                        done       = 1'b1;
                        state_next = SND_IDLE;
                    end
                end
            end
            default: state_next = SND_IDLE;
        endcase
    end

endmodule

// File: rtl/mm_host_ctrl.sv
// Host-side sequencer: loads A and B from the UART byte stream, starts the
// multiplier and hands the result phase to mm_result_sender.
module mm_host_ctrl
    import mm_pkg::*;
#(
    parameter int N  = MM_N,
    parameter int DW = MM_DW,
    parameter int RW = MM_RW,
    parameter int AW = $clog2(N * N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    output logic          wr_en,
    output logic          wr_sel,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    output logic          mm_start,
    input  logic          mm_done,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [RW-1:0] rd_data,
    output logic [7:0]    tx_data,
    output logic          tx_start,
    input  logic          tx_busy,
    output logic          busy,
    output logic          overrun
);

    localparam logic [AW:0] LAST_IDX = (AW + 1)'(N * N - 1);

    mm_ctrl_state_t state, state_next;
    logic [AW:0]    cnt;
    logic           snd_start;
    logic           snd_done;
    logic           sync_seen;
    logic           load_byte;
    logic           last_elem;

    assign sync_seen = rx_valid && (state == ST_IDLE) && (rx_data == SYNC_BYTE);
    assign load_byte = rx_valid && ((state == ST_LOAD_A) || (state == ST_LOAD_B));
    assign last_elem = (cnt == LAST_IDX);
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ST_READ stands for the whole result phase; the sender walks through
    // READ/SEND/TX_WAIT itself and reports back with snd_done.
    always_comb begin
        state_next = state;
        snd_start  = 1'b0;
        case (state)
            ST_IDLE:    if (sync_seen) state_next = ST_LOAD_A;
            ST_LOAD_A:  if (load_byte && last_elem) state_next = ST_LOAD_B;
            ST_LOAD_B:  if (load_byte && last_elem) state_next = ST_START;
            ST_START:   state_next = ST_COMPUTE;
            ST_COMPUTE: begin
                if (mm_done) begin
                    snd_start  = 1'b1;
                    state_next = ST_READ;
                end
            end
            ST_READ:    if (snd_done) state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // Registered write port and start strobe; overrun is sticky until the next SYNC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            wr_en    <= 1'b0;
            wr_sel   <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            mm_start <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            wr_en    <= load_byte;
            mm_start <= (state == ST_START);
            if (sync_seen) begin
                cnt     <= '0;
                overrun <= 1'b0;
            end else if (load_byte) begin
                wr_sel  <= (state == ST_LOAD_B);
                wr_addr <= cnt[AW-1:0];
                wr_data <= DW'(rx_data);
                cnt     <= last_elem ? '0 : cnt + (AW + 1)'(1);
            end else if (rx_valid && (state != ST_IDLE)) begin
                overrun <= 1'b1;
            end
        end
    end

    mm_result_sender #(
        .N  (N),
        .RW (RW),
        .AW (AW)
    ) u_sender (
        .clk      (clk),
        .rst      (rst),
        .start    (snd_start),
        .done     (snd_done),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_busy  (tx_busy)
    );

endmodule

// File: tb/tb_mm_host_ctrl.sv
// Self-checking bench for mm_host_ctrl with behavioural multiplier, result
// buffer and UART transmitter models.
module tb_mm_host_ctrl;
    import mm_pkg::*;

    localparam int N  = 2;
    localparam int DW = 8;
    localparam int RW = 16;
    localparam int AW = $clog2(N * N);
    localparam int NN = N * N;
    localparam int NTX = NN * (RW / 8);

    logic          clk, rst;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          wr_en, wr_sel;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          mm_start, mm_done;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [RW-1:0] rd_data;
    logic [7:0]    tx_data;
    logic          tx_start, tx_busy;
    logic          busy, overrun;

    int checks = 0;
    int errors = 0;

    logic [7:0]    a_v [NN];
    logic [7:0]    b_v [NN];
    logic [RW-1:0] res_mem [NN];
    logic [AW+8:0] exp_wr_q [$];
    logic [7:0]    exp_tx_q [$];
    logic [AW+8:0] wr_q [$];
    logic [7:0]    tx_q [$];
    int            mm_start_cnt, tx_viol, rd_cnt;
    int            tx_hold;
    int            busy_left;
    int            cd;
    logic          spur_done;

    mm_host_ctrl #(.N(N), .DW(DW), .RW(RW), .AW(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .wr_en    (wr_en),
        .wr_sel   (wr_sel),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .mm_start (mm_start),
        .mm_done  (mm_done),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_busy  (tx_busy),
        .busy     (busy),
        .overrun  (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier: done pulse 10 cycles after start.
    always @(posedge clk or posedge rst) begin
        if (rst) cd <= 0;
        else if (mm_start) cd <= 10;
        else if (cd > 0) cd <= cd - 1;
    end
    assign mm_done = (cd == 1) | spur_done;

    // Result buffer: data valid only in the cycle after rd_en.
    always @(posedge clk) rd_data <= rd_en ? res_mem[rd_addr] : 16'hDEAD;

    // Transmitter: busy for tx_hold cycles after each accepted start.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_busy   <= 1'b0;
            busy_left <= 0;
        end else if (tx_start && !tx_busy) begin
            tx_busy   <= 1'b1;
            busy_left <= tx_hold;
        end else if (busy_left > 1) begin
            busy_left <= busy_left - 1;
        end else begin
            busy_left <= 0;
            tx_busy   <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (wr_en) wr_q.push_back({wr_sel, wr_addr, wr_data});
        if (rd_en) rd_cnt++;
        if (mm_start) mm_start_cnt++;
        if (tx_start) begin
            tx_q.push_back(tx_data);
            if (tx_busy) tx_viol++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic clear_logs();
        wr_q.delete();
        tx_q.delete();
        mm_start_cnt = 0;
        tx_viol      = 0;
        rd_cnt       = 0;
    endtask

    // Reference model: matrix product from the bytes the bench sends.
    task automatic make_frame(input bit fixed);
        int s;
        exp_wr_q.delete();
        exp_tx_q.delete();
        for (int i = 0; i < NN; i++) begin
            a_v[i] = fixed ? 8'(i + 1)      : 8'($urandom);
            b_v[i] = fixed ? 8'(i + 1 + NN) : 8'($urandom);
        end
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                s = 0;
                for (int k = 0; k < N; k++) s += int'(a_v[r*N+k]) * int'(b_v[k*N+c]);
                res_mem[r*N+c] = RW'(s);
            end
        for (int i = 0; i < NN; i++) exp_wr_q.push_back({1'b0, AW'(i), a_v[i]});
        for (int i = 0; i < NN; i++) exp_wr_q.push_back({1'b1, AW'(i), b_v[i]});
        for (int i = 0; i < NN; i++) begin
            exp_tx_q.push_back(res_mem[i][15:8]);
            exp_tx_q.push_back(res_mem[i][7:0]);
        end
    endtask

    task automatic send_frame(input int max_gap);
        send_byte(SYNC_BYTE, $urandom_range(0, max_gap));
        for (int i = 0; i < NN; i++) send_byte(a_v[i], $urandom_range(0, max_gap));
        for (int i = 0; i < NN; i++) send_byte(b_v[i], $urandom_range(0, max_gap));
    endtask

    task automatic wait_idle(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(2);
        checks++;
        if ({wr_en, wr_sel, wr_addr, wr_data, mm_start, rd_en, rd_addr, tx_data, tx_start} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got %h required 0",
                     {wr_en, wr_sel, wr_addr, wr_data, mm_start, rd_en, rd_addr, tx_data, tx_start});
        end
        checks++;
        if ({busy, overrun} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_busy_overrun got %b required 00", {busy, overrun});
        end
        rst = 1'b0;
        tick(1);
    endtask

    task automatic test_basic();
        bit ok;
        logic [7:0] exp_bytes [8] = '{8'h00, 8'h13, 8'h00, 8'h16, 8'h00, 8'h2B, 8'h00, 8'h32};
        clear_logs();
        make_frame(1'b1);
        send_byte(SYNC_BYTE, 0);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("[TB] FAIL busy_rise got %b required 1", busy); end
        send_byte(a_v[0], 0);
        checks++;
        if ({wr_en, wr_sel, wr_addr, wr_data} !== {1'b1, 1'b0, AW'(0), 8'h01}) begin
            errors++;
            $display("[TB] FAIL wr_latency got %h required %h", {wr_en, wr_sel, wr_addr, wr_data},
                     {1'b1, 1'b0, AW'(0), 8'h01});
        end
        for (int i = 1; i < NN; i++) send_byte(a_v[i], i % 2);
        for (int i = 0; i < NN; i++) send_byte(b_v[i], 0);
        checks++;
        if (mm_start !== 1'b0) begin errors++; $display("[TB] FAIL start_early got %b required 0", mm_start); end
        tick(1);
        checks++;
        if (mm_start !== 1'b1) begin errors++; $display("[TB] FAIL start_pulse got %b required 1", mm_start); end
        tick(1);
        checks++;
        if (mm_start !== 1'b0) begin errors++; $display("[TB] FAIL start_width got %b required 0", mm_start); end
        wait_idle(4000, ok);
        checks++;
        if (!ok || wr_q.size() != 2 * NN || tx_q.size() != NTX || mm_start_cnt != 1) begin
            errors++;
            $display("[TB] FAIL basic_len idle=%0d writes=%0d bytes=%0d starts=%0d required 1 %0d %0d 1",
                     ok, wr_q.size(), tx_q.size(), mm_start_cnt, 2 * NN, NTX);
        end else begin
            foreach (exp_wr_q[i]) begin
                checks++;
                if (wr_q[i] !== exp_wr_q[i]) begin errors++; $display("[TB] FAIL basic_wr%0d got %h required %h", i, wr_q[i], exp_wr_q[i]); end
            end
            foreach (exp_bytes[i]) begin
                checks++;
                if (tx_q[i] !== exp_bytes[i]) begin errors++; $display("[TB] FAIL basic_tx%0d got %h required %h", i, tx_q[i], exp_bytes[i]); end
            end
        end
    endtask

    task automatic test_noise();
        bit ok;
        clear_logs();
        spur_done = 1'b1;
        tick(1);
        spur_done = 1'b0;
        send_byte(8'h00, 1);
        send_byte(8'hFF, 1);
        tick(2);
        checks++;
        if (wr_q.size() != 0 || busy !== 1'b0 || rd_cnt != 0) begin
            errors++;
            $display("[TB] FAIL noise_ignored writes=%0d busy=%b reads=%0d required 0 0 0", wr_q.size(), busy, rd_cnt);
        end
        make_frame(1'b0);
        send_frame(2);
        wait_idle(4000, ok);
        checks++;
        if (!ok || wr_q.size() != 2 * NN) begin
            errors++;
            $display("[TB] FAIL noise_len idle=%0d writes=%0d required 1 %0d", ok, wr_q.size(), 2 * NN);
        end else begin
            foreach (exp_wr_q[i]) begin
                checks++;
                if (wr_q[i] !== exp_wr_q[i]) begin errors++; $display("[TB] FAIL noise_wr%0d got %h required %h", i, wr_q[i], exp_wr_q[i]); end
            end
        end
    endtask

    task automatic test_overrun();
        bit ok;
        clear_logs();
        make_frame(1'b0);
        send_frame(0);
        tick(3);
        send_byte(8'h3C, 0);
        checks++;
        if (overrun !== 1'b1 || wr_q.size() != 2 * NN) begin
            errors++;
            $display("[TB] FAIL overrun_set got %b writes=%0d required 1 %0d", overrun, wr_q.size(), 2 * NN);
        end
        wait_idle(4000, ok);
        checks++;
        if (!ok || overrun !== 1'b1 || tx_q.size() != NTX) begin
            errors++;
            $display("[TB] FAIL overrun_sticky idle=%0d got %b bytes=%0d required 1 1 %0d", ok, overrun, tx_q.size(), NTX);
        end
        make_frame(1'b0);
        send_byte(SYNC_BYTE, 0);
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL overrun_clear got %b required 0", overrun); end
        for (int i = 0; i < NN; i++) send_byte(a_v[i], 0);
        for (int i = 0; i < NN; i++) send_byte(b_v[i], 0);
        wait_idle(4000, ok);
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL overrun_recover idle=%0d required 1", ok); end
    endtask

    task automatic test_tx_busy();
        bit ok;
        clear_logs();
        tx_hold = 200;
        make_frame(1'b0);
        send_frame(1);
        wait_idle(6000, ok);
        checks++;
        if (!ok || tx_viol != 0 || tx_q.size() != NTX) begin
            errors++;
            $display("[TB] FAIL txbusy_len idle=%0d violations=%0d bytes=%0d required 1 0 %0d", ok, tx_viol, tx_q.size(), NTX);
        end else begin
            foreach (exp_tx_q[i]) begin
                checks++;
                if (tx_q[i] !== exp_tx_q[i]) begin errors++; $display("[TB] FAIL txbusy_tx%0d got %h required %h", i, tx_q[i], exp_tx_q[i]); end
            end
        end
        tx_hold = 3;
    endtask

    task automatic test_reset_mid();
        bit ok;
        clear_logs();
        make_frame(1'b0);
        send_byte(SYNC_BYTE, 0);
        for (int i = 0; i < 3; i++) send_byte(a_v[i], 0);
        rst = 1'b1;
        tick(1);
        checks++;
        if ({wr_en, wr_sel, wr_addr, wr_data, mm_start, rd_en, rd_addr, tx_data, tx_start, busy, overrun} !== '0) begin
            errors++;
            $display("[TB] FAIL midreset_outputs got %h required 0",
                     {wr_en, wr_sel, wr_addr, wr_data, mm_start, rd_en, rd_addr, tx_data, tx_start, busy, overrun});
        end
        rst = 1'b0;
        tick(1);
        clear_logs();
        make_frame(1'b0);
        send_frame(1);
        wait_idle(4000, ok);
        checks++;
        if (!ok || wr_q.size() != 2 * NN || tx_q.size() != NTX) begin
            errors++;
            $display("[TB] FAIL midreset_len idle=%0d writes=%0d bytes=%0d required 1 %0d %0d", ok, wr_q.size(), tx_q.size(), 2 * NN, NTX);
        end else begin
            foreach (exp_wr_q[i]) begin
                checks++;
                if (wr_q[i] !== exp_wr_q[i]) begin errors++; $display("[TB] FAIL midreset_wr%0d got %h required %h", i, wr_q[i], exp_wr_q[i]); end
            end
            foreach (exp_tx_q[i]) begin
                checks++;
                if (tx_q[i] !== exp_tx_q[i]) begin errors++; $display("[TB] FAIL midreset_tx%0d got %h required %h", i, tx_q[i], exp_tx_q[i]); end
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        for (int it = 0; it < 4; it++) begin
            clear_logs();
            tx_hold = $urandom_range(1, 6);
            make_frame(1'b0);
            send_frame(0);
            wait_idle(4000, ok);
            checks++;
            if (!ok || wr_q.size() != 2 * NN || tx_q.size() != NTX || mm_start_cnt != 1) begin
                errors++;
                $display("[TB] FAIL b2b_len it=%0d idle=%0d writes=%0d bytes=%0d starts=%0d", it, ok, wr_q.size(), tx_q.size(), mm_start_cnt);
            end else begin
                foreach (exp_wr_q[i]) begin
                    checks++;
                    if (wr_q[i] !== exp_wr_q[i]) begin errors++; $display("[TB] FAIL b2b_wr%0d got %h required %h", i, wr_q[i], exp_wr_q[i]); end
                end
                foreach (exp_tx_q[i]) begin
                    checks++;
                    if (tx_q[i] !== exp_tx_q[i]) begin errors++; $display("[TB] FAIL b2b_tx%0d got %h required %h", i, tx_q[i], exp_tx_q[i]); end
                end
            end
        end
        tx_hold = 3;
    endtask

    initial begin
        rst       = 1'b0;
        rx_data   = 8'h00;
        rx_valid  = 1'b0;
        spur_done = 1'b0;
        tx_hold   = 3;
        clear_logs();
        @(negedge clk);
        test_reset();
        test_basic();
        test_noise();
        test_overrun();
        test_tx_busy();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog simulation did not complete, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
